// File: rtl/m_booth_pkg.sv
// rtl/m_booth_pkg.sv - shared Booth datapath mode constants and operand conversion
package m_booth_pkg;

    localparam logic [1:0] MODE_PASS = 2'd0;
    localparam logic [1:0] MODE_NEG  = 2'd1;
    localparam logic [1:0] MODE_ABS  = 2'd2;
    localparam logic [1:0] MODE_ONES = 2'd3;

    // Widest operand the conversion helper handles; callers pass their own width.
    localparam int CONV_MAXW = 64;

    // Converts the low w bits of x and returns {ovf, r} right-aligned, so a
    // caller casting the result to w+1 bits gets exactly {ovf, r}.
    // Negating the most negative value wraps back onto itself, which is why
    // the overflow case naturally returns the input unchanged.
    function automatic logic [CONV_MAXW:0] conv(input logic [CONV_MAXW-1:0] x,
                                                input logic [1:0]           mode,
                                                input int                   w);
        logic [CONV_MAXW-1:0] mask;
        logic [CONV_MAXW-1:0] xm;
        logic [CONV_MAXW-1:0] negx;
        logic [CONV_MAXW-1:0] min_val;
        logic [CONV_MAXW-1:0] r;
        logic [CONV_MAXW:0]   res;
        logic                 is_min;
        logic                 ovf;
        mask = '0;
        for (int i = 0; i < CONV_MAXW; i++) begin
            mask[i] = (i < w);
        end
        xm         = x & mask;
        negx       = (~xm + 1'b1) & mask;
        min_val    = '0;
        min_val[w-1] = 1'b1;
        is_min     = (xm == min_val);
        r          = xm;
        ovf        = 1'b0;
        case (mode)
            MODE_PASS: begin
                r   = xm;
                ovf = 1'b0;
            end
            MODE_NEG: begin
                r   = negx;
                ovf = is_min;
            end
            MODE_ABS: begin
                r   = xm[w-1] ? negx : xm;
                ovf = is_min;
            end
            default: begin
                r   = ~xm & mask;
                ovf = 1'b0;
            end
        endcase
        res    = {1'b0, r};
        res[w] = ovf;
        return res;
    endfunction

endpackage

// File: rtl/m_sync_fifo_mod.sv
// rtl/m_sync_fifo_mod.sv - synchronous FIFO with wrap-bit pointers
module m_sync_fifo_mod #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4,
    parameter int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNTW-1:0]  count,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = CNTW'(wr_ptr - rd_ptr);
    // Empty reads as zero so the output is clean after reset.
    assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Storage write; contents need no reset because empty masks them.
    always_ff @(posedge clock) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    // Pointer update; the extra MSB distinguishes full from empty.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/m_2s_complement_q_mod.sv
// rtl/m_2s_complement_q_mod.sv - queued two's-complement operand conversion unit
module m_2s_complement_q_mod
    import m_booth_pkg::*;
#(
    parameter int BITLEN = 5,
    parameter int DEPTH  = 4,
    parameter int CNTW   = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [BITLEN-1:0] in_tog,
    input  logic [1:0]        in_mode,
    input  logic              in_tog_valid_pulse,
    output logic              mod_busy,
    output logic [BITLEN-1:0] out_tog,
    output logic              out_ovf,
    output logic              out_tog_valid,
    input  logic              out_tog_ready,
    output logic [CNTW-1:0]   out_count,
    output logic              drop_err
);

    localparam int FW = BITLEN + 1;

    logic              stage_v;
    logic [BITLEN-1:0] stage_x;
    logic [1:0]        stage_mode;
    logic              busy_q;
    logic              drop_q;

    logic              accept;
    logic              push;
    logic              pop;
    logic [FW-1:0]     fifo_din;
    logic [FW-1:0]     fifo_dout;
    logic [CNTW-1:0]   fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNTW:0]     count_next;

    assign accept   = in_tog_valid_pulse && !busy_q;
    assign push     = stage_v && !fifo_full;
    assign pop      = !fifo_empty && out_tog_ready;
    assign fifo_din = FW'(conv(CONV_MAXW'(stage_x), stage_mode, BITLEN));

    // Occupancy after this edge: what the FIFO will hold plus the new stage entry.
    always_comb begin
        count_next = (CNTW+1)'(fifo_count) + (CNTW+1)'(push) - (CNTW+1)'(pop)
                   + (CNTW+1)'(accept);
    end

    // Stage register: holds the accepted operand for one cycle of conversion.
    always_ff @(posedge clock) begin
        if (reset) begin
            stage_v    <= 1'b0;
            stage_x    <= '0;
            stage_mode <= MODE_PASS;
        end else begin
            stage_v <= accept;
            if (accept) begin
                stage_x    <= in_tog;
                stage_mode <= in_mode;
            end
        end
    end

    // Credit check counts the in-flight stage entry, so the stage never meets a full FIFO.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            busy_q <= (count_next >= (CNTW+1)'(DEPTH));
            if (in_tog_valid_pulse && busy_q) begin
                drop_q <= 1'b1;
            end
        end
    end

    m_sync_fifo_mod #(
        .WIDTH (FW),
        .DEPTH (DEPTH),
        .CNTW  (CNTW)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_tog       = fifo_dout[BITLEN-1:0];
    assign out_ovf       = fifo_dout[BITLEN];
    assign out_tog_valid = !fifo_empty;
    assign out_count     = fifo_count + CNTW'(stage_v);
    assign mod_busy      = busy_q;
    assign drop_err      = drop_q;

endmodule

// File: tb/tb_m_2s_complement_q_mod.sv
// tb/tb_m_2s_complement_q_mod.sv - self-checking bench with queue reference model
module tb_m_2s_complement_q_mod;

    localparam int BITLEN = 5;
    localparam int DEPTH  = 4;
    localparam int CNTW   = $clog2(DEPTH + 1);

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [BITLEN-1:0] in_tog = '0;
    logic [1:0]        in_mode = 2'd0;
    logic              in_tog_valid_pulse = 1'b0;
    logic              mod_busy;
    logic [BITLEN-1:0] out_tog;
    logic              out_ovf;
    logic              out_tog_valid;
    logic              out_tog_ready = 1'b0;
    logic [CNTW-1:0]   out_count;
    logic              drop_err;

    int checks = 0;
    int errors = 0;

    logic [BITLEN:0]   mdl_q[$];
    logic              mdl_st_v;
    logic [BITLEN-1:0] mdl_st_x;
    logic [1:0]        mdl_st_m;
    logic              mdl_drop;

    m_2s_complement_q_mod #(.BITLEN(BITLEN), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .clock              (clock),
        .reset              (reset),
        .in_tog             (in_tog),
        .in_mode            (in_mode),
        .in_tog_valid_pulse (in_tog_valid_pulse),
        .mod_busy           (mod_busy),
        .out_tog            (out_tog),
        .out_ovf            (out_ovf),
        .out_tog_valid      (out_tog_valid),
        .out_tog_ready      (out_tog_ready),
        .out_count          (out_count),
        .drop_err           (drop_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Signed-integer view of the operand; results reduced modulo 32.
    function automatic logic [BITLEN:0] ref_conv(input logic [BITLEN-1:0] x, input logic [1:0] m);
        int  sv;
        int  r;
        logic ovf;
        sv  = (x >= 16) ? int'(x) - 32 : int'(x);
        ovf = 1'b0;
        case (m)
            2'd0: r = sv;
            2'd1: begin r = -sv; ovf = (sv == -16); end
            2'd2: begin r = (sv < 0) ? -sv : sv; ovf = (sv == -16); end
            default: r = -sv - 1;
        endcase
        return {ovf, BITLEN'(r)};
    endfunction

    task automatic mdl_clear();
        mdl_q.delete();
        mdl_st_v = 1'b0;
        mdl_st_x = '0;
        mdl_st_m = 2'd0;
        mdl_drop = 1'b0;
    endtask

    // Compare all outputs mid-cycle, advance the model, then cross the edge.
    task automatic step();
        logic busy;
        logic do_pop;
        int   occ;
        @(negedge clock);
        occ  = mdl_q.size() + int'(mdl_st_v);
        busy = (occ >= DEPTH);
        chk("valid", out_tog_valid, mdl_q.size() > 0);
        chk("tog",   out_tog, mdl_q.size() > 0 ? mdl_q[0][BITLEN-1:0] : 0);
        chk("ovf",   out_ovf, mdl_q.size() > 0 ? mdl_q[0][BITLEN] : 0);
        chk("count", out_count, occ);
        chk("busy",  mod_busy, busy);
        chk("drop",  drop_err, mdl_drop);
        if (reset) begin
            mdl_clear();
        end else begin
            do_pop = (mdl_q.size() > 0) && out_tog_ready;
            if (do_pop) void'(mdl_q.pop_front());
            if (mdl_st_v) mdl_q.push_back(ref_conv(mdl_st_x, mdl_st_m));
            if (in_tog_valid_pulse && busy) mdl_drop = 1'b1;
            mdl_st_v = in_tog_valid_pulse && !busy;
            if (mdl_st_v) begin
                mdl_st_x = in_tog;
                mdl_st_m = in_mode;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic req(input logic [BITLEN-1:0] x, input logic [1:0] m);
        in_tog = x;
        in_mode = m;
        in_tog_valid_pulse = 1'b1;
        step();
        in_tog_valid_pulse = 1'b0;
    endtask

    initial begin
        mdl_clear();
        repeat (2) @(posedge clock);
        #1;
        step();
        reset = 1'b0;

        // 1: single NEG, visible for exactly one cycle two edges after accept
        out_tog_ready = 1'b1;
        req(5'b00011, 2'd1);
        chk("t1_valid_early", out_tog_valid, 1'b0);
        step();
        chk("t1_valid", out_tog_valid, 1'b1);
        chk("t1_tog", out_tog, 5'b11101);
        chk("t1_ovf", out_ovf, 1'b0);
        step();
        chk("t1_valid_gone", out_tog_valid, 1'b0);

        // 2: fill without draining
        out_tog_ready = 1'b0;
        req(5'b01010, 2'd0);
        req(5'b11000, 2'd2);
        req(5'b00110, 2'd3);
        req(5'b00000, 2'd1);
        step();
        chk("t2_busy", mod_busy, 1'b1);
        chk("t2_count", out_count, 4);
        chk("t2_head", out_tog, 5'b01010);

        // 4: request while full is dropped
        req(5'b00111, 2'd1);
        chk("t4_count", out_count, 4);
        chk("t4_drop", drop_err, 1'b1);
        out_tog_ready = 1'b1;
        chk("t2_d0", out_tog, 5'b01010); step();
        chk("t2_d1", out_tog, 5'b01000); step();
        chk("t2_d2", out_tog, 5'b11001); step();
        chk("t2_d3", out_tog, 5'b00000); step();
        chk("t4_drop_kept", drop_err, 1'b1);
        chk("t2_empty", out_tog_valid, 1'b0);

        // 3: overflow corner of NEG/ABS
        req(5'b10000, 2'd1);
        req(5'b10000, 2'd2);
        chk("t3_a_tog", out_tog, 5'b10000);
        chk("t3_a_ovf", out_ovf, 1'b1);
        req(5'b01111, 2'd2);
        chk("t3_b_tog", out_tog, 5'b10000);
        chk("t3_b_ovf", out_ovf, 1'b1);
        step();
        chk("t3_c_tog", out_tog, 5'b01111);
        chk("t3_c_ovf", out_ovf, 1'b0);
        repeat (2) step();

        // 5: steady accept+pop with one queued entry
        req(5'b00001, 2'd0);
        out_tog_ready = 1'b0;
        req(5'b00010, 2'd0);
        out_tog_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req(BITLEN'($urandom), 2'($urandom));
            chk("t5_count", out_count, 2);
            chk("t5_busy", mod_busy, 1'b0);
            chk("t5_valid", out_tog_valid, 1'b1);
        end
        repeat (3) step();

        // 6: reset with three queued and one in the stage
        out_tog_ready = 1'b0;
        req(5'b00101, 2'd1);
        req(5'b00110, 2'd1);
        req(5'b00111, 2'd1);
        req(5'b01000, 2'd1);
        chk("t6_count_pre", out_count, 4);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6_valid", out_tog_valid, 1'b0);
        chk("t6_count", out_count, 0);
        chk("t6_tog", out_tog, 0);
        chk("t6_drop", drop_err, 1'b0);
        out_tog_ready = 1'b1;
        req(5'b00001, 2'd1);
        step();
        chk("t6_res", out_tog, 5'b11111);
        step();

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            in_tog             = BITLEN'($urandom);
            in_mode            = 2'($urandom);
            in_tog_valid_pulse = ($urandom_range(0, 3) != 0);
            out_tog_ready      = ($urandom_range(0, 2) != 0);
            reset              = ($urandom_range(0, 60) == 0);
            step();
        end
        reset = 1'b0;
        in_tog_valid_pulse = 1'b0;
        out_tog_ready = 1'b1;
        repeat (6) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
